mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch/data) arbiter onto one shared memory port.
// One transaction outstanding; fetch anti-starvation and wait timeout.
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    input  logic        f_kill,
    output logic [31:0] f_rdata,
    output logic        f_arrival,
    output logic        f_err,
    output logic        f_cmiss,
    input  logic        m_req,
    input  logic        m_we,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wdata,
    input  logic [3:0]  m_wstrb,
    output logic [31:0] m_rdata,
    output logic        m_arrival,
    output logic        m_err,
    output logic        m_cmiss,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);
    typedef enum logic [1:0] {IDLE, F_WAIT, M_WAIT, RESP} state_t;

    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);
    localparam logic [7:0] TO_LAST    = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic [2:0]  r_starve;
    logic [7:0]  r_to;
    logic        r_drop;
    logic        r_owner_f;
    logic        r_we;
    logic [31:0] r_f_rdata;
    logic [31:0] r_m_rdata;
    logic        r_f_err;
    logic        r_m_err;
    logic        r_f_arr;
    logic        r_m_arr;

    logic        w_idle;
    logic        w_sel_f;
    logic        w_grant;
    logic        w_wait;
    logic        w_done;
    logic        w_kill;
    logic [31:0] w_data;

    assign w_idle  = (r_state == IDLE);
    assign w_sel_f = f_req & (~m_req | (r_starve == STARVE_LIM));
    assign w_grant = w_idle & (f_req | m_req) & bus_gnt;
    assign w_wait  = (r_state == F_WAIT) | (r_state == M_WAIT);
    assign w_done  = w_wait & (bus_rvalid | (r_to == TO_LAST));
    assign w_kill  = (r_state == F_WAIT) & f_kill;
    // Timeouts and write acks both report zero data.
    assign w_data  = (bus_rvalid & ~r_we) ? bus_rdata : 32'h0;

    assign bus_req   = w_idle & (f_req | m_req);
    assign bus_we    = w_sel_f ? 1'b0 : m_we;
    assign bus_addr  = w_sel_f ? f_addr : m_addr;
    assign bus_wdata = w_sel_f ? 32'h0 : m_wdata;
    assign bus_wstrb = w_sel_f ? 4'h0 : m_wstrb;

    assign f_rdata   = r_f_rdata;
    assign f_err     = r_f_err;
    assign f_arrival = r_f_arr;
    assign m_rdata   = r_m_rdata;
    assign m_err     = r_m_err;
    assign m_arrival = r_m_arr;
    assign f_cmiss   = f_req & ~r_f_arr;
    assign m_cmiss   = m_req & ~r_m_arr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_starve  <= 3'd0;
            r_to      <= 8'd0;
            r_drop    <= 1'b0;
            r_owner_f <= 1'b0;
            r_we      <= 1'b0;
            r_f_rdata <= 32'h0;
            r_m_rdata <= 32'h0;
            r_f_err   <= 1'b0;
            r_m_err   <= 1'b0;
            r_f_arr   <= 1'b0;
            r_m_arr   <= 1'b0;
        end else begin
            r_f_arr <= 1'b0;
            r_m_arr <= 1'b0;

            if (!f_req || (w_grant && w_sel_f)) begin
                r_starve <= 3'd0;
            end else if (w_grant && r_starve != STARVE_LIM) begin
                r_starve <= r_starve + 3'd1;
            end

            unique case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_owner_f <= w_sel_f;
                        r_we      <= ~w_sel_f & m_we;
                        r_drop    <= w_sel_f & f_kill;
                        r_to      <= 8'd0;
                        r_state   <= w_sel_f ? F_WAIT : M_WAIT;
                    end
                end
                F_WAIT, M_WAIT: begin
                    if (w_kill) begin
                        r_drop <= 1'b1;
                    end
                    if (w_done) begin
                        r_state <= RESP;
                        if (r_owner_f) begin
                            // A killed fetch still drains the bus but is invisible.
                            if (!(r_drop || w_kill)) begin
                                r_f_arr   <= 1'b1;
                                r_f_rdata <= w_data;
                                r_f_err   <= ~bus_rvalid;
                            end
                        end else begin
                            r_m_arr   <= 1'b1;
                            r_m_rdata <= w_data;
                            r_m_err   <= ~bus_rvalid;
                        end
                    end else begin
                        r_to <= r_to + 8'd1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule
